// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and the transmit-queue sequencer state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int CLK_FREQ      = 25000000;
    localparam int CLKS_PER_BIT  = 217;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_BUSY = 2'd2,
        ST_GAP  = 2'd3
    } txq_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_queue_if.sv
// ============================================================================
// Module      : uart_tx_queue_if
// Description : Producer write port, queue status and UART_TX handshake of
//               the transmit queue, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_queue_if
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = 8
);

    logic                     WR_EN;
    logic [WIDTH-1:0]         WR_DATA;
    logic                     FULL;
    logic                     EMPTY;
    logic [$clog2(DEPTH):0]   COUNT;
    logic                     TX_DV;
    logic [WIDTH-1:0]         TX_BYTE;
    logic                     TX_DONE;
    logic                     OVF;
    logic [7:0]               OVF_CNT;

    // master: producer logic plus the UART_TX side
    modport master (
        output WR_EN, WR_DATA, TX_DONE,
        input  FULL, EMPTY, COUNT, TX_DV, TX_BYTE, OVF, OVF_CNT
    );

    modport slave (
        input  WR_EN, WR_DATA, TX_DONE,
        output FULL, EMPTY, COUNT, TX_DV, TX_BYTE, OVF, OVF_CNT
    );

endinterface

`default_nettype wire

// File: rtl/uart_tx_queue_sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Circular-buffer FIFO with registered count/full/empty and a
//               write-while-full (overflow) strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_wr_en,
    input  wire logic [WIDTH-1:0] i_wr_data,
    input  wire logic             i_rd_en,
    output logic      [WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic      [CW-1:0]    o_count,
    output logic                  o_ovf
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic [CW-1:0]    w_count_nxt;
    logic             w_push;
    logic             w_pop;

    // Full is judged on the registered count, so a write coinciding with a
    // pop from a full queue is still dropped.
    assign w_push      = i_wr_en && !r_full;
    assign w_pop       = i_rd_en && !r_empty;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_count;
    assign o_ovf     = i_wr_en && r_full;

endmodule

`default_nettype wire

// File: rtl/uart_tx_queue.sv
// ============================================================================
// Module      : uart_tx_queue
// Description : Byte queue and DV/Done sequencer feeding UART_TX. Define
//               UART_TXQ_OVF_CNT_EN to build the saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = 8
) (
    input wire logic        CLK,
    input wire logic        RST,
    uart_tx_queue_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    txq_state_t       r_state;
    txq_state_t       w_state_nxt;
    logic             w_pop;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_ovf_evt;
    logic             r_tx_dv;
    logic [WIDTH-1:0] r_tx_byte;
    logic             r_ovf;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .i_wr_en   (bus.WR_EN),
        .i_wr_data (bus.WR_DATA),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count),
        .o_ovf     (w_ovf_evt)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // GAP gives UART_TX one cycle to leave its cleanup state before the next DV.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_SEND;
                    w_pop       = 1'b1;
                end
            end
            ST_SEND: w_state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (bus.TX_DONE) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_tx_dv <= w_pop;
            if (w_pop) begin
                r_tx_byte <= w_rd_data;
            end
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef UART_TXQ_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf_cnt <= 8'd0;
        end else if (w_ovf_evt && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign bus.OVF_CNT = r_ovf_cnt;
`else
    assign bus.OVF_CNT = 8'd0;
`endif

    assign bus.FULL    = w_full;
    assign bus.EMPTY   = w_empty;
    assign bus.COUNT   = w_count;
    assign bus.TX_DV   = r_tx_dv;
    assign bus.TX_BYTE = r_tx_byte;
    assign bus.OVF     = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
// ============================================================================
// Module      : tb_uart_tx_queue
// Description : Randomised scoreboard bench for uart_tx_queue with a
//               behavioural UART_TX responder and a queue-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_queue;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_tx_queue_if #(.DEPTH(DEPTH), .WIDTH(8)) bus ();

    uart_tx_queue #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int dv_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: byte queue + sender availability ----
    typedef struct {
        int         at;
        logic [7:0] b;
    } dv_t;

    dv_t        sb[$];
    logic [7:0] m_q[$];
    bit         m_busy      = 0;
    int         m_pop_edge  = 0;
    int         m_free_edge = 0;
    int         m_edge      = 0;
    bit         m_ovf       = 0;
    int         m_ovf_cnt   = 0;

    function automatic void model_reset();
        m_q.delete();
        sb.delete();
        m_busy      = 0;
        m_free_edge = 0;
        m_ovf       = 0;
        m_ovf_cnt   = 0;
    endfunction

    always @(posedge CLK) begin : p_model
        int  cnt;
        bit  pop;
        dv_t e;
        m_edge++;
        if (RST) begin
            model_reset();
        end else begin
            cnt = m_q.size();
            pop = (cnt > 0) && !m_busy && (m_edge >= m_free_edge);
            // a frame's Done counts only once the start cycle is over
            if (m_busy && (m_edge > m_pop_edge + 1) && bus.TX_DONE) begin
                m_busy      = 0;
                m_free_edge = m_edge + 2;
            end
            if (pop) begin
                e.at = m_edge;
                e.b  = m_q.pop_front();
                sb.push_back(e);
                m_busy     = 1;
                m_pop_edge = m_edge;
            end
            if (bus.WR_EN) begin
                if (cnt == DEPTH) begin
                    m_ovf = 1;
`ifdef UART_TXQ_OVF_CNT_EN
                    if (m_ovf_cnt < 255) m_ovf_cnt++;
`endif
                end else begin
                    m_q.push_back(bus.WR_DATA);
                end
            end
        end
    end

    // ---------------- monitor ----------------------------------------------
    always @(negedge CLK) begin : p_mon
        dv_t         e;
        logic [15:0] exp_st;
        exp_st = {5'(m_q.size()), (m_q.size() == DEPTH), (m_q.size() == 0), m_ovf, 8'(m_ovf_cnt)};
        check("status{count,full,empty,ovf,ovf_cnt}",
              {bus.COUNT, bus.FULL, bus.EMPTY, bus.OVF, bus.OVF_CNT}, exp_st);
        if (bus.TX_DV) begin
            dv_seen++;
            if (sb.size() == 0) begin
                check("dv_unexpected", bus.TX_DV, 0);
            end else begin
                e = sb.pop_front();
                check("dv_byte", bus.TX_BYTE, e.b);
                check("dv_edge", m_edge, e.at);
            end
        end
        while (sb.size() > 0 && sb[0].at <= m_edge) begin
            e = sb.pop_front();
            check("dv_missing", bus.TX_DV, 1);
        end
    end

    // ---------------- behavioural UART_TX ----------------------------------
    int frame_len = 8;
    bit stall     = 0;
    bit stray_req = 0;
    bit u_pending = 0;
    int u_left    = 0;

    always @(negedge CLK) begin
        if (bus.TX_DV && !RST) begin
            u_pending = 1;
            u_left    = frame_len;
        end
    end

    always @(posedge CLK) begin
        #1;
        bus.TX_DONE = 1'b0;
        if (RST) begin
            u_pending = 0;
        end else if (stray_req) begin
            bus.TX_DONE = 1'b1;
            stray_req   = 0;
        end else if (u_pending && !stall) begin
            u_left--;
            if (u_left <= 0) begin
                bus.TX_DONE = 1'b1;
                u_pending   = 0;
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        bus.WR_EN   = 1'b1;
        bus.WR_DATA = d;
        tick(1);
        bus.WR_EN   = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((m_q.size() > 0 || m_busy || sb.size() > 0) && k < 20000) begin
            tick(1);
            k++;
        end
        check("drain_within_budget", (k < 20000), 1);
        tick(3);
    endtask

    task automatic check_reset(input string name);
        check(name, {bus.TX_DV, bus.TX_BYTE, bus.COUNT, bus.FULL, bus.EMPTY, bus.OVF, bus.OVF_CNT},
              {1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00});
    endtask

    logic [7:0] exp_cnt1;
    logic [7:0] exp_cnt_sat;
    int         dv_before;

    initial begin
`ifdef UART_TXQ_OVF_CNT_EN
        exp_cnt1    = 8'd1;
        exp_cnt_sat = 8'd255;
`else
        exp_cnt1    = 8'd0;
        exp_cnt_sat = 8'd0;
`endif
        bus.WR_EN   = 1'b0;
        bus.WR_DATA = 8'h00;
        bus.TX_DONE = 1'b0;
        RST         = 1'b1;
        tick(3);
        check_reset("reset_values");
        RST = 1'b0;
        tick(2);

        // single byte: DV one cycle after the write edge
        frame_len = 40;
        push(8'h63);
        check("single_empty_fell", bus.EMPTY, 0);
        tick(1);
        check("single_dv", bus.TX_DV, 1);
        check("single_byte", bus.TX_BYTE, 8'h63);
        check("single_empty_again", bus.EMPTY, 1);
        drain();

        // ordering and 2-cycle spacing at real frame length
        frame_len = 2170;
        dv_before = dv_seen;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        drain();
        check("order_dv_count", dv_seen - dv_before, 3);

        // fill and overflow with the sender stalled
        frame_len = 5;
        stall     = 1;
        for (int i = 0; i <= 16; i++) push(8'(i));
        check("fill_full", bus.FULL, 1);
        check("fill_count", bus.COUNT, 16);
        push(8'h11);
        check("ovf_flag", bus.OVF, 1);
        check("ovf_cnt_one", bus.OVF_CNT, exp_cnt1);
        stall = 0;
        drain();

        // push on the pop edge keeps COUNT steady
        stall = 1;
        push(8'hA5);
        push(8'h5A);
        check("pushpop_count", bus.COUNT, 1);
        stall = 0;
        drain();

        // 40 bytes through the ring: pointers wrap
        for (int i = 0; i < 40; i++) begin
            frame_len = $urandom_range(1, 4);
            push(8'($urandom));
            tick($urandom_range(0, 3));
        end
        drain();

        // asynchronous reset while BUSY with 5 bytes queued
        stall = 1;
        for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
        tick(3);
        #2;
        RST = 1'b1;
        #1;
        check_reset("reset_async_mid_frame");
        model_reset();
        tick(2);
        RST       = 1'b0;
        stall     = 0;
        dv_before = dv_seen;
        tick(20);
        check("reset_no_dv_after", dv_seen, dv_before);

        // stray TX_DONE in IDLE with empty queue
        stray_req = 1;
        tick(6);
        check("stray_no_dv", dv_seen, dv_before);
        check("stray_still_empty", bus.EMPTY, 1);
        stray_req = 1;
        tick(2);
        push(8'h7E);
        tick(1);
        check("stray_then_dv", bus.TX_DV, 1);
        drain();

        // overflow counter saturation
        stall = 1;
        for (int i = 0; i < 17; i++) push(8'(i + 32));
        for (int i = 0; i < 300; i++) push(8'hEE);
        check("ovf_cnt_saturated", bus.OVF_CNT, exp_cnt_sat);
        check("sat_full", bus.FULL, 1);
        stall = 0;
        drain();

        // randomised traffic with varying frame lengths and stalls
        for (int i = 0; i < 600; i++) begin
            frame_len = $urandom_range(1, 25);
            if ($urandom_range(0, 2) == 0) push(8'($urandom));
            else tick(1);
            if ($urandom_range(0, 50) == 0) stall = ~stall;
        end
        stall = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue and sender sitting directly upstream of `UART_TX`. It buffers bytes written by producer logic, such as the `UART_RX` received-byte path or a message generator. It hands them to the transmitter one at a time using `UART_TX`'s DV/Done handshake, so no byte is lost while a frame is on the wire. It replaces the single-register `enable`/`data` latch with a proper FIFO and sequencer.

## Interface
- `DEPTH`, 16: queue entries; must be a power of two, ≥ 2.
- `WIDTH`, 8: byte width; fixed to 8 for `UART_TX`.
- `CLK`  in  1: system clock (25 MHz on GoBoard).
- `RST`  in  1: reset, asynchronous, active-high.
- `WR_EN`  in  1: push `WR_DATA` this cycle.
- `WR_DATA`  in  8: byte to queue.
- `FULL`  out  1: COUNT == DEPTH.
- `EMPTY`  out  1: COUNT == 0.
- `COUNT`  out  $clog2(DEPTH)+1: entries currently held.
- `TX_DV`  out  1: one-cycle start pulse to `UART_TX` `i_TX_DV`.
- `TX_BYTE`  out  8: byte to `UART_TX` `i_TX_Byte`; valid while `TX_DV` is high, held until the next send.
- `TX_DONE`  in  1: `UART_TX` `o_TX_Done` pulse.
- `OVF`  out  1: sticky; a write was dropped because the queue was full.
- `OVF_CNT`  out  8: dropped-byte count (see Configuration).

## Operation
- **Storage.** Circular buffer with `rd_ptr`/`wr_ptr` of $clog2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0. `COUNT` is a registered value.
- **Push.** `WR_EN && !FULL` stores `WR_DATA` at `wr_ptr` and increments `wr_ptr`.
- **Push while full.** `WR_EN && FULL` drops the byte and sets `OVF`. This applies even if a pop occurs in the same cycle: `FULL` is evaluated from the registered `COUNT`.
- **Push and pop in the same cycle.** `COUNT` is unchanged and both pointers advance.
- **FSM states:**
  - IDLE: if `!EMPTY`, go to SEND.
  - SEND: one cycle only; go to BUSY.
  - BUSY: on `TX_DONE`, go to GAP.
  - GAP: one cycle only; go to IDLE. This lets `UART_TX` leave CLEANUP before the next DV.
- **Pop.** Occurs on the IDLE→SEND edge. That same edge registers `TX_BYTE <= mem[rd_ptr]`, increments `rd_ptr`, and registers `TX_DV <= 1`. `TX_DV` is high only while in SEND.
- **Stray handshake.** `TX_DONE` outside BUSY is ignored.
- **Reset values.** `RST` asserted at any time, including mid-frame:
  - Pointers and `COUNT` = 0; queued bytes discarded.
  - State IDLE, `TX_DV` = 0, `TX_BYTE` = 0.
  - `FULL` = 0, `EMPTY` = 1, `OVF` = 0, `OVF_CNT` = 0.
  - `UART_TX` is reset independently.

## Timing
- All outputs are registered.
- **Write-to-DV latency, empty queue in IDLE.** With `WR_EN` sampled at edge t, `EMPTY` falls after t. `TX_DV` is high from edge t+1 to t+2 with `TX_BYTE` = that byte, and `COUNT` returns to 0 after t+1.
- **Back-to-back bytes.** With `TX_DONE` sampled at edge d:
  - GAP occupies d..d+1; IDLE occupies d+1..d+2.
  - The next `TX_DV` is high d+2..d+3.
  - Spacing between frames is 2 cycles beyond `UART_TX`'s own frame time.
- Throughput is limited by the UART. At 217 clocks/bit, one frame is about 2170 cycles.

## Configuration
- **`UART_TXQ_OVF_CNT_EN` defined:**
  - `OVF_CNT` increments on every dropped write.
  - It saturates at 255, with no wrap.
  - It is cleared only by `RST`.
- **Not defined:** the counter logic is compiled out and `OVF_CNT` is tied to 8'd0. The sticky `OVF` flag is present in both builds.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state encoding (IDLE=0, SEND=1, BUSY=2, GAP=3).
  - `CLK_FREQ` = 25000000.
  - `CLKS_PER_BIT` = 217.
  - Default `DEPTH`.
- **Sub-module `sync_fifo`.** Holds the storage, pointers, `COUNT`, `FULL`/`EMPTY` and overflow detect. The top-level `uart_tx_queue` holds the FSM, the `TX_DV`/`TX_BYTE` registers and the `OVF`/`OVF_CNT` logic.

## Test plan
- **Single byte.** Reset, then write 0x63 at edge t → `TX_DV` is high for one cycle starting at t+1, `TX_BYTE` = 0x63, `EMPTY` = 1 after t+1, and no second DV before `TX_DONE`.
- **Ordering and spacing.** Write 0x41, 0x42, 0x43 on consecutive cycles, with a behavioural `UART_TX` model pulsing `TX_DONE` 2170 cycles after each DV → three DVs in order 0x41/0x42/0x43, each DV exactly 2 cycles after the previous `TX_DONE`.
- **Fill and overflow.** With the sender stalled (no `TX_DONE`), write 17 bytes 0x00..0x10 with DEPTH=16 → the first byte is popped, so 0x01..0x10 fill the queue (`FULL` = 1). One further write 0x11 is dropped, setting `OVF` = 1 and `OVF_CNT` = 1 (macro on) or 0 (macro off). After release, bytes are sent in order 0x00..0x10.
- **Simultaneous push/pop and wrap.** With `COUNT` = 1 in IDLE, write during the IDLE→SEND edge → `COUNT` stays 1. Run 40 bytes through the queue → pointer wrap occurs and no byte is lost or reordered.
- **Reset mid-operation.** Assert `RST` in BUSY with 5 bytes queued → all outputs take their reset values immediately (asynchronous), and no DV is issued after release until a new write.
- **Stray `TX_DONE`.** Pulse `TX_DONE` in IDLE with the queue empty → no state change and no DV. Saturation check: 300 dropped writes → `OVF_CNT` = 255.
